// File: rtl/spi_slave.sv
`timescale 1ns/1ps
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0) byte slave, MSB first.
// The sclk, mosi and cs_n pins are oversampled by clk_i through SYNC_STAGES-deep synchronisers.
// Each received byte is presented on spi_byte_data_o with a one-cycle spi_byte_vld_o strobe.
// spi_byte_data_i is shifted out on MISO during the same transfer.
// Optional feature: define SPI_SLAVE_MISO_HIZ_EN to tri-state MISO outside a frame.
module spi_slave #(
   parameter int unsigned SYNC_STAGES = 2  // must be >= 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] spi_byte_data_i,
   input  logic       spi_sclk_i,
   input  logic       spi_mosi_i,
   input  logic       spi_cs_n_i,
   output logic       spi_miso_o,
   output logic       spi_byte_vld_o,
   output logic [7:0] spi_byte_data_o
);

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic                   r_sclk_prev;
   logic                   r_cs_prev;
   // After reset the cs_n chain holds forced ones. r_settle marks when it reflects the pin again.
   logic [SYNC_STAGES-1:0] r_settle;
   // r_armed is set once a settled, deasserted cs_n has been seen. A frame in progress at
   // reset is therefore ignored until cs_n toggles.
   logic                   r_armed;
   logic [2:0]             r_bit_cnt;
   logic [7:0]             r_rx_shift;
   logic [7:0]             r_tx_shift;
   logic                   r_byte_vld;
   logic [7:0]             r_byte_data;

   logic w_sclk;
   logic w_mosi;
   logic w_cs;
   logic w_active;
   logic w_sclk_rise;
   logic w_sclk_fall;
   logic w_cs_fall;
   logic w_miso_drive;

   assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
   assign w_cs        = r_cs_sync[SYNC_STAGES-1];
   assign w_active    = r_armed & ~w_cs;
   assign w_sclk_rise = w_sclk & ~r_sclk_prev;
   assign w_sclk_fall = ~w_sclk & r_sclk_prev;
   assign w_cs_fall   = r_armed & ~w_cs & r_cs_prev;

   // Pin synchronisers, edge-detect history and frame arming.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_cs_sync   <= '1;
         r_sclk_prev <= 1'b0;
         r_cs_prev   <= 1'b1;
         r_settle    <= '0;
         r_armed     <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n_i};
         r_sclk_prev <= w_sclk;
         r_cs_prev   <= w_cs;
         r_settle    <= {r_settle[SYNC_STAGES-2:0], 1'b1};
         if (r_settle[SYNC_STAGES-1] && w_cs) begin
            r_armed <= 1'b1;
         end
      end
   end

   // Receive path: shift MOSI on sclk rises and strobe every eighth bit.
   // A cs_n rise makes w_active low in that cycle, so a coincident sclk rise is dropped.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_bit_cnt   <= 3'd0;
         r_rx_shift  <= 8'h00;
         r_byte_vld  <= 1'b0;
         r_byte_data <= 8'h00;
      end else begin
         r_byte_vld <= 1'b0;
         if (!w_active) begin
            r_bit_cnt <= 3'd0;
         end else if (w_sclk_rise) begin
            r_rx_shift <= {r_rx_shift[6:0], w_mosi};
            r_bit_cnt  <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               r_byte_data <= {r_rx_shift[6:0], w_mosi};
               r_byte_vld  <= 1'b1;
            end
         end
      end
   end

   // Transmit path: load on frame start and on the first sclk fall of each byte, else shift.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_tx_shift <= 8'h00;
      end else if (w_cs_fall) begin
         r_tx_shift <= spi_byte_data_i;
      end else if (w_active && w_sclk_fall) begin
         if (r_bit_cnt == 3'd0) begin
            r_tx_shift <= spi_byte_data_i;
         end else begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
         end
      end
   end

   assign w_miso_drive = w_active & ~rst_i;

`ifdef SPI_SLAVE_MISO_HIZ_EN
   assign spi_miso_o = w_miso_drive ? r_tx_shift[7] : 1'bz;
`else
   assign spi_miso_o = w_miso_drive ? r_tx_shift[7] : 1'b0;
`endif

   assign spi_byte_vld_o  = r_byte_vld;
   assign spi_byte_data_o = r_byte_data;

endmodule

// File: tb/tb_spi_slave.sv
`timescale 1ns/1ps
// Testbench for spi_slave: directed test-plan steps plus randomized frames checked against
// a byte-level model (full bytes received, MISO byte k = start value + k).
module tb_spi_slave;

   localparam int SCLK_HALF = 20;  // sclk half-period in ns; covers sync + update latency

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_base = 8'h00;
   logic [7:0] data_in;
   logic       sclk = 1'b0;
   logic       mosi = 1'b0;
   logic       cs_n = 1'b1;
   wire        miso;
   logic       vld;
   logic [7:0] data_out;

   // Monitor state: written only by the monitor process.
   logic [7:0] rx_log [512];
   int         vld_count = 0;
   int         b2b_count = 0;
   logic       vld_prev = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;
   int rd_ptr   = 0;

   // Consumer behaviour: the byte to send advances by one on every strobe.
   assign data_in = tx_base + 8'(vld_count);

   spi_slave #(.SYNC_STAGES(2)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .spi_byte_data_i (data_in),
      .spi_sclk_i      (sclk),
      .spi_mosi_i      (mosi),
      .spi_cs_n_i      (cs_n),
      .spi_miso_o      (miso),
      .spi_byte_vld_o  (vld),
      .spi_byte_data_o (data_out)
   );

   always #2.5 clk = ~clk;

   // Strobe monitor sampled on the falling clk edge, away from the active edge.
   always @(negedge clk) begin
      if (vld) begin
         if (vld_prev) b2b_count = b2b_count + 1;
         rx_log[vld_count % 512] = data_out;
         vld_count = vld_count + 1;
      end
      vld_prev = vld;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
   endtask

   task automatic next_rx(output logic [7:0] b);
      b = rx_log[rd_ptr % 512];
      rd_ptr++;
   endtask

   task automatic frame_start();
      cs_n = 1'b0;
      #(2 * SCLK_HALF);
   endtask

   task automatic frame_end();
      #(SCLK_HALF);
      cs_n = 1'b1;
      #(2 * SCLK_HALF);
   endtask

   // Clocks nbits of b out MSB first; m collects MISO sampled at each sclk rise.
   task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] m);
      m = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         mosi = b[7 - i];
         #(SCLK_HALF);
         sclk = 1'b1;
         m = {m[6:0], miso};
         #(SCLK_HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic check_miso_idle(input string tag);
`ifdef SPI_SLAVE_MISO_HIZ_EN
      check(tag, {7'd0, (miso === 1'bz)}, 8'h01);
`else
      check(tag, {7'd0, miso}, 8'h00);
`endif
   endtask

   initial begin
      logic [7:0] m;
      logic [7:0] b;
      logic [7:0] got;
      logic [7:0] exp_tx;
      logic [7:0] exp_q[$];
      int         cnt0;
      int         nb;
      int         np;

      // Reset state
      repeat (4) @(posedge clk);
      #1;
      check("rst_vld", {7'd0, vld}, 8'h00);
      check("rst_data", data_out, 8'h00);
      check_miso_idle("rst_miso");
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check_miso_idle("idle_miso");

      // Two bytes in one frame
      cnt0 = vld_count;
      frame_start();
`ifdef SPI_SLAVE_MISO_HIZ_EN
      check("active_miso_driven", {7'd0, (miso === 1'bz)}, 8'h00);
`endif
      xfer(8'h2A, 8, m);
      xfer(8'h2B, 8, m);
      frame_end();
      check("t1_count", 8'(vld_count - cnt0), 8'd2);
      next_rx(got); check("t1_byte0", got, 8'h2A);
      next_rx(got); check("t1_byte1", got, 8'h2B);
      check("t1_hold", data_out, 8'h2B);

      // MISO sequence 7E..82 with the consumer advancing on each strobe
      tx_base = 8'h7E - 8'(vld_count);
      cnt0 = vld_count;
      exp_q.delete();
      frame_start();
      for (int k = 0; k < 5; k++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         xfer(b, 8, m);
         check("t2_miso", m, 8'h7E + 8'(k));
      end
      frame_end();
      check("t2_count", 8'(vld_count - cnt0), 8'd5);
      foreach (exp_q[k]) begin
         next_rx(got);
         check("t2_rx", got, exp_q[k]);
      end

      // 0x2A, 0x2B then 24 zero bits
      cnt0 = vld_count;
      frame_start();
      xfer(8'h2A, 8, m);
      xfer(8'h2B, 8, m);
      for (int k = 0; k < 3; k++) xfer(8'h00, 8, m);
      frame_end();
      check("t3_count", 8'(vld_count - cnt0), 8'd5);
      next_rx(got); check("t3_b0", got, 8'h2A);
      next_rx(got); check("t3_b1", got, 8'h2B);
      for (int k = 0; k < 3; k++) begin
         next_rx(got);
         check("t3_zero", got, 8'h00);
      end
      check("t3_hold", data_out, 8'h00);

      // Partial byte aborted by cs_n, then a full 0xA5
      cnt0 = vld_count;
      frame_start();
      xfer(8'hFF, 5, m);
      frame_end();
      check("t4_partial_count", 8'(vld_count - cnt0), 8'd0);
      check("t4_hold", data_out, 8'h00);
      frame_start();
      xfer(8'hA5, 8, m);
      frame_end();
      check("t4_count", 8'(vld_count - cnt0), 8'd1);
      next_rx(got); check("t4_byte", got, 8'hA5);

      // Reset mid-byte, then a fresh frame
      frame_start();
      xfer(8'h3C, 8, m);
      xfer(8'hC3, 4, m);
      check("t5_pre", data_out, 8'h3C);
      next_rx(got);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t5_rst_vld", {7'd0, vld}, 8'h00);
      check("t5_rst_data", data_out, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      cnt0 = vld_count;
      xfer(8'h0F, 4, m);  // rest of the aborted byte, cs_n still low
      frame_end();
      check("t5_no_strobe", 8'(vld_count - cnt0), 8'd0);
      frame_start();
      xfer(8'h96, 8, m);
      frame_end();
      check("t5_count", 8'(vld_count - cnt0), 8'd1);
      next_rx(got); check("t5_byte", got, 8'h96);
      check_miso_idle("t5_idle_miso");

      // Randomized frames with optional trailing partial bytes
      tx_base = 8'($urandom) - 8'(vld_count);
      exp_tx  = tx_base + 8'(vld_count);
      cnt0 = vld_count;
      exp_q.delete();
      for (int f = 0; f < 12; f++) begin
         nb = $urandom_range(0, 3);
         np = $urandom_range(0, 7);
         frame_start();
         for (int j = 0; j < nb; j++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            xfer(b, 8, m);
            check("rnd_miso", m, exp_tx);
            exp_tx = exp_tx + 8'd1;
         end
         if (np > 0) begin
            b = 8'($urandom);
            xfer(b, np, m);
            check("rnd_miso_part", m, 8'(exp_tx >> (8 - np)));
         end
         frame_end();
      end
      check("rnd_count", 8'(vld_count - cnt0), 8'(exp_q.size()));
      foreach (exp_q[k]) begin
         next_rx(got);
         check("rnd_rx", got, exp_q[k]);
      end

      check("no_back_to_back", 8'(b2b_count), 8'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
